// File: rtl/seg7_scan.sv
// ============================================================================
// seg7_scan : 4-digit common-anode hex display scanner with per-frame snapshot
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module seg7_scan #(
    parameter int REFRESH_DIV = 12500,
    parameter int GUARD       = 16
) (
    input  logic        clk50MHz,
    input  logic        reset,
    input  logic [31:0] disp_dat,
    input  logic        half_sel,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int C_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    digit_t               r_idx;
    digit_t               w_idx_next;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [15:0]          r_snap;
    logic                 r_snap_half;
    logic                 w_tick;
    logic                 w_take;
    logic                 w_blank;
    logic                 w_lit;
    logic [3:0]           w_nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_tick = (r_cnt == C_CNT_W'(REFRESH_DIV - 1));
    assign w_take = w_tick && (r_idx == DIG3);

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            r_idx <= DIG0;
        end else begin
            r_idx <= w_idx_next;
        end
    end

    always_comb begin
        w_idx_next = r_idx;
        if (w_tick) begin
            case (r_idx)
                DIG0:    w_idx_next = DIG1;
                DIG1:    w_idx_next = DIG2;
                DIG2:    w_idx_next = DIG3;
                default: w_idx_next = DIG0;
            endcase
        end
    end

    // Input word is sampled only at frame boundaries so a frame never tears.
    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            r_snap      <= 16'h0000;
            r_snap_half <= 1'b0;
        end else if (w_take) begin
            r_snap      <= half_sel ? disp_dat[31:16] : disp_dat[15:0];
            r_snap_half <= half_sel;
        end
    end

    always_comb begin
        w_blank = 1'b0;
        w_nib   = r_snap[3:0];
        case (r_idx)
            DIG0: begin
                w_nib   = r_snap[3:0];
                w_blank = 1'b0;
            end
            DIG1: begin
                w_nib   = r_snap[7:4];
                w_blank = blank_lz && (r_snap[15:4] == 12'h000);
            end
            DIG2: begin
                w_nib   = r_snap[11:8];
                w_blank = blank_lz && (r_snap[15:8] == 8'h00);
            end
            default: begin
                w_nib   = r_snap[15:12];
                w_blank = blank_lz && (r_snap[15:12] == 4'h0);
            end
        endcase
    end

    assign w_lit = (r_cnt >= C_CNT_W'(GUARD)) && !w_blank;

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            an         <= 4'b1111;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= w_lit ? ~(4'b0001 << r_idx) : 4'b1111;
            seg        <= w_lit ? hex7(w_nib) : 7'h7F;
            dp         <= (w_lit && (r_idx == DIG3) && r_snap_half) ? 1'b0 : 1'b1;
            frame_tick <= w_take;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// ============================================================================
// tb_seg7_scan : directed, table-driven check of seg7_scan (REFRESH_DIV=8, GUARD=2)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan;

    localparam int RD = 8;
    localparam int GD = 2;

    logic        clk50MHz = 1'b0;
    logic        reset;
    logic [31:0] disp_dat;
    logic        half_sel;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk50MHz   (clk50MHz),
        .reset      (reset),
        .disp_dat   (disp_dat),
        .half_sel   (half_sel),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk50MHz = ~clk50MHz;

    // seg_e[d] = 7'h7F marks a blanked digit; dp_e bit low = decimal point lit
    typedef struct {
        logic [31:0]      dat;
        logic             hs;
        logic             lz;
        logic [3:0][6:0]  seg_e;
        logic [3:0]       dp_e;
    } vec_t;

    vec_t vecs[8];

    task automatic check_dark(input string tag);
        n_tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: an=%b seg=%h dp=%b ft=%b, want an=1111 seg=7f dp=1 ft=0",
                     tag, an, seg, dp, frame_tick);
        end
    endtask

    // Wait for a frame_tick strictly after the call; new inputs are then on display.
    task automatic wait_tick(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk50MHz);
            if (frame_tick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s: frame_tick=0 after 100 cycles, want 1", tag);
        end
    endtask

    // Checks one full frame cycle by cycle, starting the cycle after frame_tick.
    task automatic check_frame(input logic [3:0][6:0] seg_e, input logic [3:0] dp_e,
                               input int chg_at, input logic [31:0] chg_dat,
                               input string tag);
        logic       lit;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ft;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < RD; c++) begin
                @(negedge clk50MHz);
                if (d * RD + c == chg_at) disp_dat = chg_dat;
                lit   = (c >= GD) && (seg_e[d] != 7'h7F);
                e_an  = lit ? ~(4'b0001 << d) : 4'b1111;
                e_seg = lit ? seg_e[d] : 7'h7F;
                e_dp  = (lit && !dp_e[d]) ? 1'b0 : 1'b1;
                e_ft  = (d == 3) && (c == RD - 1);
                n_tests++;
                if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_tick !== e_ft) begin
                    n_fail++;
                    $display("FAIL %s d%0d c%0d: an=%b seg=%h dp=%b ft=%b, want an=%b seg=%h dp=%b ft=%b",
                             tag, d, c, an, seg, dp, frame_tick, e_an, e_seg, e_dp, e_ft);
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
        vecs[1] = '{32'h1234ABCD, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0111};
        vecs[2] = '{32'h000000A0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40}, 4'b1111};
        vecs[3] = '{32'h00000000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[4] = '{32'h0000F00F, 1'b0, 1'b1, {7'h0E, 7'h40, 7'h40, 7'h0E}, 4'b1111};
        vecs[5] = '{32'h00010000, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79}, 4'b1111};
        vecs[6] = '{32'h89EF0000, 1'b1, 1'b0, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0111};
        vecs[7] = '{32'h00005E67, 1'b0, 1'b0, {7'h12, 7'h06, 7'h02, 7'h78}, 4'b1111};

        reset    = 1'b1;
        disp_dat = 32'h1234ABCD;
        half_sel = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk50MHz);
        check_dark("reset_hold");
        reset = 1'b0;
        // snapshot is still zero until the first frame boundary
        check_frame({4{7'h40}}, 4'b1111, -1, 32'h0, "first_frame");

        for (int i = 0; i < 8; i++) begin
            disp_dat = vecs[i].dat;
            half_sel = vecs[i].hs;
            blank_lz = vecs[i].lz;
            wait_tick($sformatf("vec%0d_tick", i));
            check_frame(vecs[i].seg_e, vecs[i].dp_e, -1, 32'h0, $sformatf("vec%0d", i));
        end

        // Mid-frame data change must not appear until the next snapshot.
        disp_dat = 32'h0000FFFF;
        half_sel = 1'b0;
        blank_lz = 1'b0;
        wait_tick("snap_tick");
        check_frame({4{7'h0E}}, 4'b1111, RD + 2, 32'h00001111, "snap_hold");
        check_frame({4{7'h79}}, 4'b1111, -1, 32'h0, "snap_next");

        // Reset in the middle of a lit DIG2 slot.
        disp_dat = 32'h1234ABCD;
        wait_tick("rst_tick");
        repeat (2 * RD + 4) @(negedge clk50MHz);
        n_tests++;
        if (an !== 4'b1011 || seg !== 7'h03) begin
            n_fail++;
            $display("FAIL pre_reset_dig2: an=%b seg=%h, want an=1011 seg=03", an, seg);
        end
        reset = 1'b1;
        #1;
        check_dark("reset_async");
        @(negedge clk50MHz);
        check_dark("reset_mid");
        reset = 1'b0;
        check_frame({4{7'h40}}, 4'b1111, -1, 32'h0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
